// File: rtl/mem_acc_pkg.sv
// Shared types and lane helpers for the mem_access_ctrl load/store initiator.
// Memory is little-endian and word-wide; byte lane n occupies bits [8n+7:8n].
package mem_acc_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input size_e       size,
        input logic [1:0]  addr_lo
    );
        logic [31:0] merged;
        merged = word;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input size_e       size,
        input logic        is_signed,
        input logic [1:0]  addr_lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: result = {{24{is_signed & b[7]}}, b};
            SZ_HALF: result = {{16{is_signed & h[15]}}, h};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_acc_lane.sv
// Combinational lane unit: merges store data into the read word and
// extracts/extends load data from it.
module mem_acc_lane
    import mem_acc_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    assign merged    = lane_merge(rd_word, wdata, size, addr_lo);
    assign extracted = lane_extract(rd_word, size, is_signed, addr_lo);

endmodule

// File: rtl/mem_access_ctrl.sv
// Non-pipelined load/store initiator for a word-wide memory; sub-word stores are
// read-modify-write. Optional performance counters: MEM_ACC_PERF_CNT_EN.
module mem_access_ctrl
    import mem_acc_pkg::*;
#(
    parameter int RAM_SIZE_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
`ifdef MEM_ACC_PERF_CNT_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_errs
`endif
);

    state_e      state_q, next_state;
    logic [31:0] addr_q, wdata_q, rd_word_q;
    size_e       size_q;
    logic        signed_q, write_q, err_q;
    logic        accept, req_err, addr_oor;
    logic [31:0] merged, extracted;

    assign accept   = req_valid & (state_q == S_IDLE);
    assign addr_oor = (req_addr >> (RAM_SIZE_BIT + 2)) != 32'd0;
    assign req_err  = (req_size == SZ_ILL)
                    | ((req_size == SZ_HALF) & req_addr[0])
                    | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                    | addr_oor;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_BYTE;
            signed_q  <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_word_q <= '0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= size_e'(req_size);
                signed_q <= req_signed;
                write_q  <= req_write;
                err_q    <= req_err;
            end
            if (state_q == S_RD) begin
                rd_word_q <= mem_read_data;
            end
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        next_state = S_RESP;
                    else if (!req_write || (req_size != SZ_WORD))
                        next_state = S_RD;
                    else
                        next_state = S_WR;
                end
            end
            S_RD:    next_state = write_q ? S_WR : S_RESP;
            S_WR:    next_state = S_RESP;
            S_RESP:  if (rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    mem_acc_lane u_lane (
        .rd_word   (rd_word_q),
        .wdata     (wdata_q),
        .size      (size_q),
        .is_signed (signed_q),
        .addr_lo   (addr_q[1:0]),
        .merged    (merged),
        .extracted (extracted)
    );

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_err        = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;
        mem_address    = {addr_q[31:2], 2'b00};
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_RD:   mem_read  = 1'b1;
            S_WR: begin
                mem_write      = 1'b1;
                mem_write_data = merged;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q | write_q) ? 32'd0 : extracted;
            end
            default: ;
        endcase
    end

`ifdef MEM_ACC_PERF_CNT_EN
    logic rsp_fire;
    assign rsp_fire = (state_q == S_RESP) & rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (rsp_fire) begin
            if (err_q)
                perf_errs <= perf_errs + 32'd1;
            else if (write_q)
                perf_stores <= perf_stores + 32'd1;
            else
                perf_loads <= perf_loads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory fed by the DUT, checked against a
// byte-addressed reference model. Define MEM_ACC_PERF_CNT_EN to cover the counters.
module tb_mem_access_ctrl;

    localparam int RAM_BITS = 8;
    localparam int NWORDS   = 1 << RAM_BITS;
    localparam int NBYTES   = 4 * NWORDS;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;
`ifdef MEM_ACC_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

    int compared   = 0;
    int mismatched = 0;
    int wr_pulses  = 0;
    int rd_pulses  = 0;
    int overlap    = 0;
    int exp_loads  = 0;
    int exp_stores = 0;
    int exp_errs   = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_waddr = '0;
    logic        mem_loaded = 1'b0;

    logic [31:0] mem   [NWORDS];
    logic [7:0]  ref_b [NBYTES];

    always #5 clk = ~clk;

    mem_access_ctrl #(.RAM_SIZE_BIT(RAM_BITS)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
`ifdef MEM_ACC_PERF_CNT_EN
        ,
        .perf_loads     (perf_loads),
        .perf_stores    (perf_stores),
        .perf_errs      (perf_errs)
`endif
    );

    assign mem_read_data = mem[mem_address[RAM_BITS+1:2]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= $urandom;
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address[RAM_BITS+1:2]] <= mem_write_data;
        end
        if (mem_read && mem_write) overlap++;
        if (mem_read) rd_pulses++;
        if (mem_write) begin
            wr_pulses++;
            last_wdata = mem_write_data;
            last_waddr = mem_address;
        end
    end

    // Reference model: byte-addressed little-endian memory.
    function automatic bit ref_error(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a >= NBYTES) return 1'b1;
        if ((a % (32'd1 << sz)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_b[a + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int wa);
        return {ref_b[4*wa+3], ref_b[4*wa+2], ref_b[4*wa+1], ref_b[4*wa]};
    endfunction

    // Drives one transaction with rsp_ready high; returns observed and model values.
    task automatic run_txn(
        input  logic w, input logic [1:0] sz, input logic sg,
        input  logic [31:0] a, input logic [31:0] wd,
        output logic [31:0] got_rd, output logic got_err, output int lat, output int nwr,
        output logic [31:0] exp_rd, output logic exp_err, output int exp_lat
    );
        int wr0;
        exp_err = ref_error(sz, a);
        exp_rd  = '0;
        if (exp_err) begin
            exp_lat = 1;
            exp_errs++;
        end else if (!w) begin
            exp_rd  = ref_load(sz, sg, a);
            exp_lat = 2;
            exp_loads++;
        end else begin
            ref_store(sz, a, wd);
            exp_lat = (sz == 2'd2) ? 2 : 3;
            exp_stores++;
        end
        wr0 = wr_pulses;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) lat = -1;
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        @(posedge clk); #1;
        nwr = wr_pulses - wr0;
    endtask

    task automatic test_reset();
        compared++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 ||
            mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: ready=%b rv=%b rd=%h err=%b mr=%b mw=%b addr=%h wd=%h, want 1 0 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_address, mem_write_data);
        end
`ifdef MEM_ACC_PERF_CNT_EN
        compared++;
        if (perf_loads !== 32'd0 || perf_stores !== 32'd0 || perf_errs !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_perf: %0d %0d %0d, want 0 0 0", perf_loads, perf_stores, perf_errs);
        end
`endif
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic er, eer; int lat, nwr, elat;
        run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, nwr, erd, eer, elat);
        compared++;
        if (nwr !== 1 || last_waddr !== 32'h10 || last_wdata !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL word_store_mem: writes=%0d addr=%h data=%h, want 1 00000010 deadbeef", nwr, last_waddr, last_wdata);
        end
        compared++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
            mismatched++;
            $display("FAIL word_store_rsp: lat=%0d err=%b rd=%h, want 2 0 0", lat, er, rd);
        end
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nwr, erd, eer, elat);
        compared++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2 || nwr !== 0) begin
            mismatched++;
            $display("FAIL word_load: rd=%h err=%b lat=%0d writes=%0d, want deadbeef 0 2 0", rd, er, lat, nwr);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, erd; logic er, eer; int lat, nwr, elat, rd0;
        run_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, er, lat, nwr, erd, eer, elat);
        rd0 = rd_pulses;
        run_txn(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AB, rd, er, lat, nwr, erd, eer, elat);
        compared++;
        if (last_wdata !== 32'h11AB3344 || nwr !== 1 || rd_pulses - rd0 !== 1 || lat !== 3) begin
            mismatched++;
            $display("FAIL byte_store: data=%h writes=%0d reads=%0d lat=%0d, want 11ab3344 1 1 3",
                     last_wdata, nwr, rd_pulses - rd0, lat);
        end
        run_txn(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, rd, er, lat, nwr, erd, eer, elat);
        compared++;
        if (rd !== 32'hFFFFFFAB || er !== 1'b0 || lat !== 2) begin
            mismatched++;
            $display("FAIL byte_load_signed: rd=%h err=%b lat=%0d, want ffffffab 0 2", rd, er, lat);
        end
        run_txn(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, rd, er, lat, nwr, erd, eer, elat);
        compared++;
        if (rd !== 32'h000000AB || er !== 1'b0) begin
            mismatched++;
            $display("FAIL byte_load_unsigned: rd=%h err=%b, want 000000ab 0", rd, er);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd, erd; logic er, eer; int lat, nwr, elat;
        run_txn(1'b1, 2'd1, 1'b0, 32'h26, 32'h00008001, rd, er, lat, nwr, erd, eer, elat);
        compared++;
        if (last_wdata[31:16] !== 16'h8001 || last_wdata !== ref_word(9) || last_waddr !== 32'h24 || lat !== 3) begin
            mismatched++;
            $display("FAIL half_store: data=%h addr=%h lat=%0d, want %h 00000024 3", last_wdata, last_waddr, lat, ref_word(9));
        end
        run_txn(1'b0, 2'd1, 1'b1, 32'h26, 32'h0, rd, er, lat, nwr, erd, eer, elat);
        compared++;
        if (rd !== 32'hFFFF8001 || er !== 1'b0 || lat !== 2) begin
            mismatched++;
            $display("FAIL half_load_signed: rd=%h err=%b lat=%0d, want ffff8001 0 2", rd, er, lat);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer; int lat, nwr, elat, r0, w0;
        logic [1:0]  sz_t [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [31:0] ad_t [4] = '{32'h13, 32'h21, 32'h40, 32'h400};
        logic        wr_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            r0 = rd_pulses; w0 = wr_pulses;
            run_txn(wr_t[i], sz_t[i], 1'b1, ad_t[i], 32'hFFFF_FFFF, rd, er, lat, nwr, erd, eer, elat);
            compared++;
            if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || rd_pulses !== r0 || wr_pulses !== w0) begin
                mismatched++;
                $display("FAIL error_case%0d: err=%b rd=%h lat=%0d reads=%0d writes=%0d, want 1 0 1 0 0",
                         i, er, rd, lat, rd_pulses - r0, wr_pulses - w0);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] r0, exp2; logic e0; int lat;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        compared++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || lat !== 2) begin
            mismatched++;
            $display("FAIL stall_first_rsp: rv=%b rd=%h lat=%0d, want 1 deadbeef 2", rsp_valid, rsp_rdata, lat);
        end
        r0 = rsp_rdata; e0 = rsp_err;
        exp2 = ref_load(2'd2, 1'b0, 32'h20);
        req_valid = 1'b1; req_addr = 32'h20;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            compared++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_hold%0d: rv=%b rd=%h err=%b ready=%b, want 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, r0, e0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_read !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_release: rv=%b ready=%b mr=%b, want 0 1 0", rsp_valid, req_ready, mem_read);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        compared++;
        if (mem_read !== 1'b1 || req_ready !== 1'b0 || mem_address !== 32'h20) begin
            mismatched++;
            $display("FAIL stall_accept: mr=%b ready=%b addr=%h, want 1 0 00000020", mem_read, req_ready, mem_address);
        end
        @(posedge clk); #1;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp2 || rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_second_rsp: rv=%b rd=%h err=%b, want 1 %h 0", rsp_valid, rsp_rdata, rsp_err, exp2);
        end
        @(posedge clk); #1;
        exp_loads += 2;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a; logic er, eer, w, sg; logic [1:0] sz; int lat, nwr, elat, enwr;
        for (int n = 0; n < 80; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
            run_txn(w, sz, sg, a, $urandom, rd, er, lat, nwr, erd, eer, elat);
            enwr = (w && !eer) ? 1 : 0;
            compared++;
            if (rd !== erd || er !== eer || lat !== elat || nwr !== enwr) begin
                mismatched++;
                $display("FAIL random%0d w=%b sz=%0d addr=%h: rd=%h err=%b lat=%0d writes=%0d, want %h %b %0d %0d",
                         n, w, sz, a, rd, er, lat, nwr, erd, eer, elat, enwr);
            end
            if (w && !eer) begin
                compared++;
                if (mem[a[RAM_BITS+1:2]] !== ref_word(int'(a[RAM_BITS+1:2]))) begin
                    mismatched++;
                    $display("FAIL random%0d_memword: got %h, want %h", n, mem[a[RAM_BITS+1:2]],
                             ref_word(int'(a[RAM_BITS+1:2])));
                end
            end
        end
        compared++;
        if (overlap !== 0) begin
            mismatched++;
            $display("FAIL read_write_overlap: %0d cycles, want 0", overlap);
        end
    endtask

`ifdef MEM_ACC_PERF_CNT_EN
    task automatic test_perf();
        compared++;
        if (perf_loads !== 32'(exp_loads) || perf_stores !== 32'(exp_stores) || perf_errs !== 32'(exp_errs)) begin
            mismatched++;
            $display("FAIL perf_counts: %0d %0d %0d, want %0d %0d %0d",
                     perf_loads, perf_stores, perf_errs, exp_loads, exp_stores, exp_errs);
        end
    endtask
`endif

    task automatic test_reset_mid_wr();
        logic [31:0] old_word, rd, erd; logic er, eer; int lat, nwr, elat;
        old_word = ref_word(12);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h31; req_wdata = 32'h5A; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (mem_write !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_wr_reached: mw=%b, want 1", mem_write);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
            mismatched++;
            $display("FAIL rst_async: mw=%b mr=%b ready=%b rv=%b rd=%h err=%b addr=%h wd=%h, want 0 0 1 0 0 0 0 0",
                     mem_write, mem_read, req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_write_data);
        end
        @(posedge clk); #1;
        compared++;
        if (mem[12] !== old_word) begin
            mismatched++;
            $display("FAIL rst_mem_unchanged: got %h, want %h", mem[12], old_word);
        end
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
`ifdef MEM_ACC_PERF_CNT_EN
        test_perf();
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat, nwr, erd, eer, elat);
        compared++;
        if (rd !== old_word || er !== 1'b0 || lat !== 2) begin
            mismatched++;
            $display("FAIL rst_recover_load: rd=%h err=%b lat=%0d, want %h 0 2", rd, er, lat, old_word);
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        #1;
        test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NWORDS; i++)
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = mem[i][8*k +: 8];
        @(posedge clk); #1;
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_stall();
        test_random();
`ifdef MEM_ACC_PERF_CNT_EN
        test_perf();
`endif
        test_reset_mid_wr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
